// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score counter.
// SCORE_BLANK_EN (optional) enables leading-zero blanking of the score digits.
package score_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef bcd_digit_t [3:0] score_t;

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    COMMIT
  } state_t;

  localparam bcd_digit_t BCD_MAX    = 4'd9;
  localparam bcd_digit_t BLANK_CODE = 4'd10;
  localparam score_t     SCORE_MAX  = {BCD_MAX, BCD_MAX, BCD_MAX, BCD_MAX};

  // Digit-wise magnitude compare, most significant digit decides first.
  function automatic logic score_gt(score_t a, score_t b);
    logic gt;
    logic done;
    gt   = 1'b0;
    done = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!done && a[i] != b[i]) begin
        gt   = (a[i] > b[i]);
        done = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/bcd_digit_inc.sv
// One BCD digit incrementer stage: wraps 9 -> 0 and raises carry.
module bcd_digit_inc
  import score_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  logic       carry_i,
  output bcd_digit_t digit_o,
  output logic       carry_o
);

  always_comb begin
    digit_o = digit_i;
    carry_o = 1'b0;
    if (carry_i) begin
      if (digit_i >= BCD_MAX) begin
        digit_o = '0;
        carry_o = 1'b1;
      end else begin
        digit_o = digit_i + 4'd1;
      end
    end
  end

endmodule

// File: rtl/score_counter.sv
// Running score and session high score in 4-digit BCD.
// Define SCORE_BLANK_EN for leading-zero blanking on the score outputs.
module score_counter
  import score_pkg::*;
#(
  parameter int TICKS_PER_POINT = 6,
  parameter int BONUS_W         = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               run,
  input  logic               clear,
  input  logic               bonus_valid,
  input  logic [BONUS_W-1:0] bonus_amount,
  output logic               bonus_ready,
  output bcd_digit_t         score_d0,
  output bcd_digit_t         score_d1,
  output bcd_digit_t         score_d2,
  output bcd_digit_t         score_d3,
  output bcd_digit_t         high_d0,
  output bcd_digit_t         high_d1,
  output bcd_digit_t         high_d2,
  output bcd_digit_t         high_d3,
  output logic               new_high,
  output logic               saturated
);

  localparam logic [5:0] TICK_LAST = 6'(TICKS_PER_POINT - 1);

  state_t             state_q;
  logic [5:0]         tick_q;
  logic [BONUS_W-1:0] pend_q;
  logic               tick_pend_q;
  score_t             score_q;
  score_t             score_d;
  score_t             score_inc;
  score_t             high_q;
  logic               new_high_q;
  logic               sat_q;

  logic               running;
  logic               tick_wrap;
  logic               drain;
  logic               xfer;
  logic               inc;
  logic [4:0]         carry;

  assign running     = (state_q == RUNNING);
  assign tick_wrap   = running && frame_tick && (tick_q == TICK_LAST);
  assign drain       = running && (pend_q != '0);
  assign bonus_ready = running && (pend_q == '0);
  assign xfer        = bonus_valid && bonus_ready;

  // Drain wins the single +1 slot; a tick point waits in tick_pend_q.
  assign inc = running && (drain || tick_wrap || tick_pend_q)
            && (score_q != SCORE_MAX);

  assign carry[0] = inc;

  for (genvar i = 0; i < 4; i++) begin : g_dig
    bcd_digit_inc u_dig (
      .digit_i (score_q[i]),
      .carry_i (carry[i]),
      .digit_o (score_inc[i]),
      .carry_o (carry[i+1])
    );
  end

  assign score_d = carry[4] ? SCORE_MAX : score_inc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      pend_q      <= '0;
      tick_pend_q <= 1'b0;
      score_q     <= '0;
      high_q      <= '0;
      new_high_q  <= 1'b0;
      sat_q       <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      pend_q      <= '0;
      tick_pend_q <= 1'b0;
      score_q     <= '0;
      new_high_q  <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (run) state_q <= RUNNING;
        end
        RUNNING: begin
          if (!run) state_q <= COMMIT;
        end
        COMMIT: begin
          state_q <= IDLE;
          if (score_gt(score_q, high_q)) begin
            high_q     <= score_q;
            new_high_q <= 1'b1;
          end else begin
            new_high_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (running) begin
        if (frame_tick) tick_q <= tick_wrap ? '0 : tick_q + 6'd1;
        score_q <= score_d;
        sat_q   <= (score_d == SCORE_MAX);

        if (drain && tick_wrap) tick_pend_q <= 1'b1;
        else if (!drain)        tick_pend_q <= 1'b0;

        if (xfer)       pend_q <= bonus_amount;
        else if (drain) pend_q <= pend_q - 1'b1;

        if (!run) begin
          pend_q      <= '0;
          tick_pend_q <= 1'b0;
        end
      end
    end
  end

  score_t score_out;

`ifdef SCORE_BLANK_EN
  always_comb begin
    score_out = score_q;
    if (score_q[3] == '0) begin
      score_out[3] = BLANK_CODE;
      if (score_q[2] == '0) begin
        score_out[2] = BLANK_CODE;
        if (score_q[1] == '0) score_out[1] = BLANK_CODE;
      end
    end
  end
`else
  assign score_out = score_q;
`endif

  assign score_d0  = score_out[0];
  assign score_d1  = score_out[1];
  assign score_d2  = score_out[2];
  assign score_d3  = score_out[3];
  assign high_d0   = high_q[0];
  assign high_d1   = high_q[1];
  assign high_d2   = high_q[2];
  assign high_d3   = high_q[3];
  assign new_high  = new_high_q;
  assign saturated = sat_q;

endmodule
